// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer
//
// Wishbone write master that fills the frame buffer with a 32bpp test image,
// one word per pixel in raster order, before the display core scans it out.
// done_o is used downstream to release the display init sequence.
//
// Ports:
//   wb_clk, reset      Wishbone clock, asynchronous active-high reset
//   start_i            single-cycle pulse that begins a frame fill
//   pattern_i          0 bars, 1 grey gradient, 2 32x32 checker, 3 solid fill
//   fill_i             RGB888 colour for the solid fill pattern
//   busy_o             fill in progress
//   done_o             fill completed or aborted; held until next start
//   err_o              sticky abort flag after a bus error; cleared by start
//   wbm_*              Wishbone master write port (sel and bte are constant)
//
// Build option:
//   FBW_BURST_EN       when defined, writes use 8-beat incrementing bursts
//                      with a one-cycle bus release between bursts.
//                      When undefined, classic single cycles are issued.

module fb_pattern_writer #(
    parameter logic [31:0] FB_BASE = 32'h0003_c000,
    parameter int          H_RES   = 640,
    parameter int          V_RES   = 480,
    parameter int          BAR_W   = 80
) (
    input  logic        wb_clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [1:0]  pattern_i,
    input  logic [23:0] fill_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
`ifdef FBW_BURST_EN
    localparam logic [1:0] ST_GAP   = 2'd2;
`endif
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [9:0] X_LAST   = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_RES - 1);
    localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

    logic [1:0]  state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [9:0]  bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        cyc_q, cyc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  pattern_q, pattern_d;
    logic [23:0] fill_q, fill_d;
`ifdef FBW_BURST_EN
    logic [2:0]  beat_q, beat_d;
`endif

    logic [9:0]  x_nx, y_nx, bar_cnt_nx;
    logic [2:0]  bar_idx_nx;
    logic        last_pixel;

    // Colour bar order white, yellow, cyan, green, magenta, red, blue, black
    // falls out of the bar index bits directly: R is on when bit1 is clear,
    // G when bit2 is clear, B when bit0 is clear.
    function automatic logic [23:0] pixel_rgb(input logic [1:0]  pat,
                                              input logic [23:0] fill,
                                              input logic [7:0]  px,
                                              input logic        py5,
                                              input logic [2:0]  bar);
        logic [23:0] rgb;
        case (pat)
            2'd0:    rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
            2'd1:    rgb = {px, px, px};
            2'd2:    rgb = (px[5] ^ py5) ? 24'hffffff : 24'h000000;
            default: rgb = fill;
        endcase
        return rgb;
    endfunction

    // Coordinates of the pixel after the current one. The bar sub-counter
    // replaces a divide by BAR_W and restarts with every new line.
    always_comb begin
        x_nx       = x_q + 10'd1;
        y_nx       = y_q;
        bar_cnt_nx = bar_cnt_q + 10'd1;
        bar_idx_nx = bar_idx_q;
        if (bar_cnt_q == BAR_LAST) begin
            bar_cnt_nx = '0;
            bar_idx_nx = bar_idx_q + 3'd1;
        end
        if (x_q == X_LAST) begin
            x_nx       = '0;
            y_nx       = y_q + 10'd1;
            bar_cnt_nx = '0;
            bar_idx_nx = '0;
        end
        last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);
    end

    // Main sequencer. The next pixel word is registered on the same edge
    // that takes the ack, so a zero-wait slave sees one pixel per clock.
    // A bus error takes priority over a simultaneous ack.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cyc_d     = cyc_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
`ifdef FBW_BURST_EN
        beat_d    = beat_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    pattern_d = pattern_i;
                    fill_d    = fill_i;
                    x_d       = '0;
                    y_d       = '0;
                    bar_cnt_d = '0;
                    bar_idx_d = '0;
                    adr_d     = FB_BASE;
                    dat_d     = {8'h00, pixel_rgb(pattern_i, fill_i, 8'd0, 1'b0, 3'd0)};
                    cyc_d     = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_WRITE;
`ifdef FBW_BURST_EN
                    beat_d    = '0;
`endif
                end
            end
            ST_WRITE: begin
                if (wbm_err_i) begin
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (wbm_ack_i) begin
                    if (last_pixel) begin
                        cyc_d   = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        x_d       = x_nx;
                        y_d       = y_nx;
                        bar_cnt_d = bar_cnt_nx;
                        bar_idx_d = bar_idx_nx;
                        adr_d     = adr_q + 32'd4;
                        dat_d     = {8'h00, pixel_rgb(pattern_q, fill_q, x_nx[7:0],
                                                      y_nx[5], bar_idx_nx)};
`ifdef FBW_BURST_EN
                        // Beat counter wraps to 0, ready for the next burst.
                        beat_d = beat_q + 3'd1;
                        if (beat_q == 3'd7) begin
                            cyc_d   = 1'b0;
                            state_d = ST_GAP;
                        end
`endif
                    end
                end
            end
`ifdef FBW_BURST_EN
            ST_GAP: begin
                cyc_d   = 1'b1;
                state_d = ST_WRITE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            adr_q     <= FB_BASE;
            dat_q     <= '0;
            cyc_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            pattern_q <= '0;
            fill_q    <= '0;
`ifdef FBW_BURST_EN
            beat_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            cyc_q     <= cyc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
`ifdef FBW_BURST_EN
            beat_q    <= beat_d;
`endif
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = 4'b1111;
    assign wbm_we_o  = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_bte_o = 2'b00;
`ifdef FBW_BURST_EN
    assign wbm_cti_o = cyc_q ? ((beat_q == 3'd7) ? 3'b111 : 3'b010) : 3'b000;
`else
    assign wbm_cti_o = 3'b000;
`endif

endmodule

// File: tb/tb_fb_pattern_writer.sv
// tb_fb_pattern_writer
//
// Two writer instances: a small 16x4 frame (bar width 2) for complete fills,
// error abort, mid-fill start and reset, and a 64x40 frame (bar width 8)
// driven by a slave with random wait states for the checker pattern.
// Expected pixels come from a coordinate-based reference model.

module tb_fb_pattern_writer;

    localparam logic [31:0] BASE = 32'h0003_c000;
    localparam int SH = 16;
    localparam int SV = 4;
    localparam int SB = 2;
    localparam int CH = 64;
    localparam int CV = 40;
    localparam int CB = 8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Small instance
    logic        smStart, smBusy, smDone, smErr, smWe, smStb, smCyc, smAck, smErrIn;
    logic [1:0]  smPattern, smBte;
    logic [23:0] smFill;
    logic [31:0] smAdr, smDat;
    logic [3:0]  smSel;
    logic [2:0]  smCti;

    // Checker instance
    logic        ckStart, ckBusy, ckDone, ckErr, ckWe, ckStb, ckCyc, ckAck, ckErrIn;
    logic [1:0]  ckPattern, ckBte;
    logic [23:0] ckFill;
    logic [31:0] ckAdr, ckDat;
    logic [3:0]  ckSel;
    logic [2:0]  ckCti;

    int checks = 0;
    int errors = 0;
    logic [31:0] capWords [64];

    fb_pattern_writer #(.FB_BASE(BASE), .H_RES(SH), .V_RES(SV), .BAR_W(SB)) dutSmall (
        .wb_clk(clk), .reset(reset), .start_i(smStart), .pattern_i(smPattern),
        .fill_i(smFill), .busy_o(smBusy), .done_o(smDone), .err_o(smErr),
        .wbm_adr_o(smAdr), .wbm_dat_o(smDat), .wbm_sel_o(smSel), .wbm_we_o(smWe),
        .wbm_stb_o(smStb), .wbm_cyc_o(smCyc), .wbm_cti_o(smCti), .wbm_bte_o(smBte),
        .wbm_ack_i(smAck), .wbm_err_i(smErrIn)
    );

    fb_pattern_writer #(.FB_BASE(BASE), .H_RES(CH), .V_RES(CV), .BAR_W(CB)) dutCheck (
        .wb_clk(clk), .reset(reset), .start_i(ckStart), .pattern_i(ckPattern),
        .fill_i(ckFill), .busy_o(ckBusy), .done_o(ckDone), .err_o(ckErr),
        .wbm_adr_o(ckAdr), .wbm_dat_o(ckDat), .wbm_sel_o(ckSel), .wbm_we_o(ckWe),
        .wbm_stb_o(ckStb), .wbm_cyc_o(ckCyc), .wbm_cti_o(ckCti), .wbm_bte_o(ckBte),
        .wbm_ack_i(ckAck), .wbm_err_i(ckErrIn)
    );

    // Reference pixel from frame coordinates and the pattern rules.
    function automatic logic [31:0] expPixel(input logic [1:0] pat, input logic [23:0] fill,
                                             input int x, input int y, input int barW);
        logic [7:0]  g;
        logic [23:0] rgb;
        case (pat)
            2'd0: begin
                case (x / barW)
                    0:       rgb = 24'hffffff;
                    1:       rgb = 24'hffff00;
                    2:       rgb = 24'h00ffff;
                    3:       rgb = 24'h00ff00;
                    4:       rgb = 24'hff00ff;
                    5:       rgb = 24'hff0000;
                    6:       rgb = 24'h0000ff;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd1: begin
                g   = 8'(x % 256);
                rgb = {g, g, g};
            end
            2'd2:    rgb = (((x / 32) % 2) != ((y / 32) % 2)) ? 24'hffffff : 24'h000000;
            default: rgb = fill;
        endcase
        return {8'h00, rgb};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulse start on the small instance, then scramble pattern/fill so the
    // bench can tell whether they were latched.
    task automatic applyStimulus(input logic [1:0] pat, input logic [23:0] fill);
        @(negedge clk);
        smPattern = pat;
        smFill    = fill;
        smStart   = 1'b1;
        @(negedge clk);
        smStart   = 1'b0;
        smPattern = 2'($urandom);
        smFill    = 24'($urandom);
    endtask

    task automatic checkSmallReset(input string tag);
        checkOutput({tag, "_cyc"},  32'(smCyc), 32'd0);
        checkOutput({tag, "_stb"},  32'(smStb), 32'd0);
        checkOutput({tag, "_we"},   32'(smWe), 32'd0);
        checkOutput({tag, "_busy"}, 32'(smBusy), 32'd0);
        checkOutput({tag, "_done"}, 32'(smDone), 32'd0);
        checkOutput({tag, "_err"},  32'(smErr), 32'd0);
        checkOutput({tag, "_adr"},  smAdr, BASE);
        checkOutput({tag, "_dat"},  smDat, 32'd0);
        checkOutput({tag, "_cti"},  32'(smCti), 32'd0);
    endtask

    // Runs one fill on the small instance with a zero-wait slave. errBeat,
    // startAt and resetAt select the beat at which a bus error, a stray
    // start pulse or an asynchronous reset is injected (-1 = never).
    task automatic runSmall(input logic [1:0] pat, input logic [23:0] fill,
                            input int errBeat, input int startAt, input int resetAt,
                            output int nWrites, output int nGaps);
        int  n = 0;
        int  gap = 0;
        int  cycles = 0;
        bit  prevCyc = 1'b1;
        bit  expectEnd = 1'b0;
        bit  errDriven = 1'b0;
        bit  finished = 1'b0;
        nGaps = 0;
        applyStimulus(pat, fill);
        checkOutput("start_busy", 32'(smBusy), 32'd1);
        checkOutput("start_err_clr", 32'(smErr), 32'd0);
        checkOutput("start_done_clr", 32'(smDone), 32'd0);
        while (!finished && cycles < 400) begin
            if (expectEnd) begin
                smAck = 1'b0;
                smErrIn = 1'b0;
                checkOutput("end_cyc_drop", 32'(smCyc), 32'd0);
                checkOutput("end_done", 32'(smDone), 32'd1);
                checkOutput("end_busy", 32'(smBusy), 32'd0);
                checkOutput("end_err", 32'(smErr), 32'(errDriven));
                finished = 1'b1;
            end else if (smCyc) begin
                if (!prevCyc) begin
`ifdef FBW_BURST_EN
                    checkOutput("gap_len", gap, 32'd1);
`else
                    checkOutput("gap_len", gap, 32'd0);
`endif
                    nGaps++;
                    gap = 0;
                end
                checkOutput("stb", 32'(smStb), 32'd1);
                checkOutput("we", 32'(smWe), 32'd1);
                checkOutput("adr", smAdr, BASE + 32'(4 * n));
                checkOutput("dat", smDat, expPixel(pat, fill, n % SH, n / SH, SB));
`ifdef FBW_BURST_EN
                checkOutput("cti", 32'(smCti), (n % 8 == 7) ? 32'd7 : 32'd2);
`else
                checkOutput("cti", 32'(smCti), 32'd0);
`endif
                if (n < 64) capWords[n] = smDat;
                smStart = (n == startAt);
                if (n == startAt) checkOutput("busy_at_restart", 32'(smBusy), 32'd1);
                if (n == resetAt) begin
                    smAck = 1'b0;
                    smErrIn = 1'b0;
                    smStart = 1'b0;
                    #2 reset = 1'b1;
                    #1 checkOutput("async_cyc", 32'(smCyc), 32'd0);
                    checkSmallReset("rst_mid");
                    @(negedge clk);
                    reset = 1'b0;
                    finished = 1'b1;
                end else if (n == errBeat) begin
                    smErrIn = 1'b1;
                    smAck = ($urandom_range(0, 1) == 1);
                    errDriven = 1'b1;
                    expectEnd = 1'b1;
                end else begin
                    smAck = 1'b1;
                    smErrIn = 1'b0;
                    if (n == SH * SV - 1) expectEnd = 1'b1;
                end
                n++;
                prevCyc = 1'b1;
            end else begin
                smAck = 1'b0;
                smErrIn = 1'b0;
                smStart = 1'b0;
                gap++;
                prevCyc = 1'b0;
            end
            if (!finished) begin
                @(negedge clk);
                cycles++;
            end
        end
        smAck = 1'b0;
        smErrIn = 1'b0;
        smStart = 1'b0;
        checkOutput("fill_finished", 32'(finished), 32'd1);
        nWrites = n;
    endtask

    // Checker pattern on the larger frame with 0-3 random wait states.
    task automatic runChecker();
        int n = 0;
        int waitLeft = 0;
        int cycles = 0;
        bit newBeat = 1'b1;
        logic [31:0] heldAdr, heldDat;
        logic [31:0] word32x0, word32x32;
        int target = 32 * CH + 32;
        word32x0 = 'x;
        word32x32 = 'x;
        @(negedge clk);
        ckPattern = 2'd2;
        ckFill = 24'($urandom);
        ckStart = 1'b1;
        @(negedge clk);
        ckStart = 1'b0;
        ckPattern = 2'($urandom);
        while (n <= target && cycles < 20000) begin
            if (ckCyc) begin
                if (newBeat) begin
                    checkOutput("ck_adr", ckAdr, BASE + 32'(4 * n));
                    checkOutput("ck_dat", ckDat, expPixel(2'd2, 24'd0, n % CH, n / CH, CB));
                    if (n == 32) word32x0 = ckDat;
                    if (n == target) word32x32 = ckDat;
                    heldAdr = ckAdr;
                    heldDat = ckDat;
                    waitLeft = $urandom_range(0, 3);
                    newBeat = 1'b0;
                end else begin
                    checkOutput("ck_adr_stable", ckAdr, heldAdr);
                    checkOutput("ck_dat_stable", ckDat, heldDat);
                end
                if (waitLeft > 0) begin
                    ckAck = 1'b0;
                    waitLeft--;
                end else begin
                    ckAck = 1'b1;
                    n++;
                    newBeat = 1'b1;
                end
            end else begin
                ckAck = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        ckAck = 1'b0;
        checkOutput("ck_progress", 32'(n > target), 32'd1);
        checkOutput("ck_pixel_32_0", word32x0, 32'h00ffffff);
        checkOutput("ck_pixel_32_32", word32x32, 32'h00000000);
    endtask

    initial begin
        int nWrites;
        int nGaps;
        reset = 1'b1;
        smStart = 1'b0; smPattern = '0; smFill = '0; smAck = 1'b0; smErrIn = 1'b0;
        ckStart = 1'b0; ckPattern = '0; ckFill = '0; ckAck = 1'b0; ckErrIn = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkSmallReset("idle");
        checkOutput("idle_sel", 32'(smSel), 32'hf);
        checkOutput("idle_bte", 32'(smBte), 32'd0);

        // Colour bars over the whole small frame
        runSmall(2'd0, 24'($urandom), -1, -1, -1, nWrites, nGaps);
        checkOutput("bars_writes", nWrites, 32'd64);
        checkOutput("bars_word0", capWords[0], 32'h00ffffff);
        checkOutput("bars_word14", capWords[14], 32'h00000000);
        checkOutput("bars_last_adr", BASE + 32'd252, 32'h0003_c0fc);
`ifdef FBW_BURST_EN
        checkOutput("burst_gaps", nGaps, 32'd7);
`else
        checkOutput("classic_gaps", nGaps, 32'd0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("done_held", 32'(smDone), 32'd1);

        // Checker pattern with wait states
        runChecker();

        // Solid fill aborted by a bus error on the fifth beat
        runSmall(2'd3, 24'h123456, 4, -1, -1, nWrites, nGaps);
        checkOutput("err_beats", nWrites, 32'd5);
        repeat (4) @(negedge clk);
        checkOutput("err_sticky", 32'(smErr), 32'd1);
        checkOutput("err_cyc_low", 32'(smCyc), 32'd0);

        // Restart clears err_o and refills from the base address
        runSmall(2'd3, 24'h123456, -1, -1, -1, nWrites, nGaps);
        checkOutput("refill_writes", nWrites, 32'd64);
        checkOutput("refill_word0", capWords[0], 32'h00123456);

        // Gradient with an ignored start at pixel 5 and reset at pixel 10
        runSmall(2'd1, 24'($urandom), -1, 5, 10, nWrites, nGaps);
        checkOutput("rst_beats", nWrites, 32'd11);
        repeat (2) @(negedge clk);
        checkSmallReset("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
